// File: rtl/vscale_wb_stage.sv
// Writeback stage: retires one ALU result or pending load into the regfile, with bypass and load-use stall.
// Optional: define VSCALE_WB_LOAD_BYPASS_EN to forward load data in the dmem_rvalid cycle.
module vscale_wb_stage #(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_wa,
  input  logic [XPR_LEN-1:0]        ex_wd,
  input  logic                      ex_is_load,
  input  logic [2:0]                ex_mem_type,
  input  logic [1:0]                ex_addr_lo,
  input  logic                      dmem_rvalid,
  input  logic [XPR_LEN-1:0]        dmem_rdata,
  input  logic [REG_ADDR_WIDTH-1:0] de_ra1,
  input  logic [REG_ADDR_WIDTH-1:0] de_ra2,
  output logic                      wen,
  output logic [REG_ADDR_WIDTH-1:0] wa,
  output logic [XPR_LEN-1:0]        wd,
  output logic                      bypass_rs1,
  output logic                      bypass_rs2,
  output logic [XPR_LEN-1:0]        bypass_data,
  output logic                      load_use_stall,
  output logic                      retire
);

  // state     | meaning
  // EMPTY     | no instruction held
  // ALU       | ALU result held, completes this cycle
  // LOAD_WAIT | load held, completes when dmem_rvalid
  typedef enum logic [1:0] {EMPTY, ALU, LOAD_WAIT} state_t;

  state_t                    state;
  logic                      wb_wen;
  logic [REG_ADDR_WIDTH-1:0] wb_wa;
  logic [XPR_LEN-1:0]        wb_data;
  logic [2:0]                wb_mem_type;
  logic [1:0]                wb_addr_lo;

  logic                      accept;
  logic                      complete;
  logic                      load_done;
  logic                      byp_ok;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [XPR_LEN-1:0]        load_data;

  assign ex_ready  = (state != LOAD_WAIT) || dmem_rvalid;
  assign accept    = ex_valid && ex_ready;
  assign load_done = (state == LOAD_WAIT) && dmem_rvalid;
  assign complete  = (state == ALU) || load_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      wb_wen      <= 1'b0;
      wb_wa       <= '0;
      wb_data     <= '0;
      wb_mem_type <= 3'd0;
      wb_addr_lo  <= 2'd0;
    end else if (accept) begin
      state       <= ex_is_load ? LOAD_WAIT : ALU;
      wb_wen      <= ex_wen;
      wb_wa       <= ex_wa;
      wb_data     <= ex_wd;
      wb_mem_type <= ex_mem_type;
      wb_addr_lo  <= ex_addr_lo;
    end else if (complete) begin
      state <= EMPTY;
    end
  end

  always_comb begin
    ld_byte = 8'd0;
    case (wb_addr_lo)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = wb_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  // Undefined funct3 encodings fall through to a full-word load.
  always_comb begin
    load_data = dmem_rdata;
    case (wb_mem_type)
      3'd0: load_data = {{(XPR_LEN-8){ld_byte[7]}}, ld_byte};
      3'd1: load_data = {{(XPR_LEN-16){ld_half[15]}}, ld_half};
      3'd4: load_data = {{(XPR_LEN-8){1'b0}}, ld_byte};
      3'd5: load_data = {{(XPR_LEN-16){1'b0}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

`ifdef VSCALE_WB_LOAD_BYPASS_EN
  assign byp_ok = 1'b1;
`else
  assign byp_ok = (state != LOAD_WAIT);
`endif

  assign retire      = complete;
  assign wen         = complete && wb_wen && (wb_wa != '0);
  assign wa          = wb_wa;
  assign wd          = load_done ? load_data : wb_data;
  assign bypass_data = wd;
  assign bypass_rs1  = wen && byp_ok && (de_ra1 == wa);
  assign bypass_rs2  = wen && byp_ok && (de_ra2 == wa);

  assign load_use_stall = (state == LOAD_WAIT) && wb_wen && (wb_wa != '0) &&
                          ((de_ra1 == wb_wa) || (de_ra2 == wb_wa)) &&
                          !(dmem_rvalid && byp_ok);

endmodule

// File: tb/tb_vscale_wb_stage.sv
// Bench for vscale_wb_stage: directed vector table, reset-during-load sequence, random run against a slot model.
module tb_vscale_wb_stage;

`ifdef VSCALE_WB_LOAD_BYPASS_EN
  localparam bit LBYP = 1'b1;
`else
  localparam bit LBYP = 1'b0;
`endif

  logic        clk, reset_n;
  logic        ex_valid, ex_ready, ex_wen, ex_is_load;
  logic [4:0]  ex_wa, de_ra1, de_ra2, wa;
  logic [31:0] ex_wd, dmem_rdata, wd, bypass_data;
  logic [2:0]  ex_mem_type;
  logic [1:0]  ex_addr_lo;
  logic        dmem_rvalid, wen, bypass_rs1, bypass_rs2, load_use_stall, retire;

  int total = 0;
  int bad   = 0;

  vscale_wb_stage #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .ex_is_load(ex_is_load), .ex_mem_type(ex_mem_type), .ex_addr_lo(ex_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .de_ra1(de_ra1), .de_ra2(de_ra2),
    .wen(wen), .wa(wa), .wd(wd), .bypass_rs1(bypass_rs1), .bypass_rs2(bypass_rs2),
    .bypass_data(bypass_data), .load_use_stall(load_use_stall), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        v, w, ld, rv;
    bit [4:0]  a, ra1, ra2;
    bit [31:0] d, rdata;
    bit [2:0]  mt;
    bit [1:0]  lo;
    bit        e_rdy, e_wen, e_chkwd, e_b1, e_b2, e_stall, e_ret;
    bit [4:0]  e_wa;
    bit [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, bit w, bit [4:0] a, bit [31:0] d, bit ld, bit [2:0] mt,
                              bit [1:0] lo, bit rv, bit [31:0] rdata, bit [4:0] ra1, bit [4:0] ra2,
                              bit e_rdy, bit e_wen, bit [4:0] e_wa, bit e_chkwd, bit [31:0] e_wd,
                              bit e_b1, bit e_b2, bit e_stall, bit e_ret);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.ld = ld; t.mt = mt; t.lo = lo; t.rv = rv;
    t.rdata = rdata; t.ra1 = ra1; t.ra2 = ra2;
    t.e_rdy = e_rdy; t.e_wen = e_wen; t.e_wa = e_wa; t.e_chkwd = e_chkwd; t.e_wd = e_wd;
    t.e_b1 = e_b1; t.e_b2 = e_b2; t.e_stall = e_stall; t.e_ret = e_ret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit w, input bit [4:0] a, input bit [31:0] d, input bit ld,
                       input bit [2:0] mt, input bit [1:0] lo, input bit rv, input bit [31:0] rdata,
                       input bit [4:0] ra1, input bit [4:0] ra2);
    ex_valid = v; ex_wen = w; ex_wa = a; ex_wd = d; ex_is_load = ld; ex_mem_type = mt;
    ex_addr_lo = lo; dmem_rvalid = rv; dmem_rdata = rdata; de_ra1 = ra1; de_ra2 = ra2;
  endtask

  task automatic check_all(input string tag, input bit e_rdy, input bit e_wen, input bit [4:0] e_wa,
                           input bit e_chkwd, input bit [31:0] e_wd, input bit e_b1, input bit e_b2,
                           input bit e_stall, input bit e_ret);
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(e_rdy));
    chk({tag, ".wen"}, 32'(wen), 32'(e_wen));
    chk({tag, ".wa"}, 32'(wa), 32'(e_wa));
    chk({tag, ".bypass_rs1"}, 32'(bypass_rs1), 32'(e_b1));
    chk({tag, ".bypass_rs2"}, 32'(bypass_rs2), 32'(e_b2));
    chk({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(e_stall));
    chk({tag, ".retire"}, 32'(retire), 32'(e_ret));
    if (e_chkwd) begin
      chk({tag, ".wd"}, wd, e_wd);
      chk({tag, ".bypass_data"}, bypass_data, e_wd);
    end
  endtask

  // Reference load extraction by shifting and two's-complement arithmetic.
  function automatic bit [31:0] extract(bit [2:0] mt, bit [1:0] lo, bit [31:0] rdata);
    bit [31:0] b, h;
    b = (rdata >> (8 * lo)) & 32'hFF;
    h = (rdata >> (16 * lo[1])) & 32'hFFFF;
    case (mt)
      3'd0: return (b > 127) ? b - 32'd256 : b;
      3'd4: return b;
      3'd1: return (h > 32767) ? h - 32'd65536 : h;
      3'd5: return h;
      default: return rdata;
    endcase
  endfunction

  // Model: a single slot holding the instruction waiting to retire.
  bit        m_valid, m_load, m_wen;
  bit [4:0]  m_wa;
  bit [31:0] m_wd;
  bit [2:0]  m_mt;
  bit [1:0]  m_lo;

  initial begin
    bit        v, w, ld, rv, done, rdy, ok, ewen, stall;
    bit [4:0]  a, r1, r2;
    bit [31:0] d, rdata, ewd;
    bit [2:0]  mt;
    bit [1:0]  lo;

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    check_all("reset", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    //           v w a  d             ld mt lo rv rdata          ra1 ra2 | rdy wen wa chk wd            b1 b2    stall  ret
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,0,     1,0,0, 1,32'h0,        0,0,    0,     0));
    vecs.push_back(mk(1,1,5, 32'h12345678, 0,0,0, 0,0,            5,0,     1,0,0, 1,32'h0,        0,0,    0,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            5,0,     1,1,5, 1,32'h12345678, 1,0,    0,     1));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            5,0,     1,0,5, 1,32'h12345678, 0,0,    0,     0));
    vecs.push_back(mk(1,1,0, 32'hABC,      0,0,0, 0,0,            0,0,     1,0,5, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,0,     1,0,0, 1,32'hABC,      0,0,    0,     1));
    vecs.push_back(mk(1,1,7, 0,            1,0,3, 0,0,            0,7,     1,0,0, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,7,     0,0,7, 0,0,            0,0,    1,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,7,     0,0,7, 0,0,            0,0,    1,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 1,32'h80FF0000, 0,7,     1,1,7, 1,32'hFFFFFF80, 0,LBYP, !LBYP, 1));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,7,     1,0,7, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(1,1,8, 0,            1,5,2, 0,0,            0,0,     1,0,7, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 1,32'h9ABC1234, 0,0,     1,1,8, 1,32'h00009ABC, 0,0,    0,     1));
    vecs.push_back(mk(1,1,9, 0,            1,1,2, 0,0,            0,0,     1,0,8, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 1,32'h9ABC1234, 0,0,     1,1,9, 1,32'hFFFF9ABC, 0,0,    0,     1));
    vecs.push_back(mk(1,1,1, 32'h11,       0,0,0, 0,0,            0,0,     1,0,9, 0,0,            0,0,    0,     0));
    vecs.push_back(mk(1,1,2, 32'h22,       0,0,0, 0,0,            0,0,     1,1,1, 1,32'h11,       0,0,    0,     1));
    vecs.push_back(mk(1,1,3, 0,            1,2,0, 0,0,            0,0,     1,1,2, 1,32'h22,       0,0,    0,     1));
    vecs.push_back(mk(1,1,4, 32'h44,       0,0,0, 1,32'hDEADBEEF, 0,0,     1,1,3, 1,32'hDEADBEEF, 0,0,    0,     1));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,0,     1,1,4, 1,32'h44,       0,0,    0,     1));
    vecs.push_back(mk(0,0,0, 0,            0,0,0, 0,0,            0,0,     1,0,4, 0,0,            0,0,    0,     0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].ld, vecs[i].mt, vecs[i].lo,
            vecs[i].rv, vecs[i].rdata, vecs[i].ra1, vecs[i].ra2);
      #3;
      check_all($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_wen, vecs[i].e_wa, vecs[i].e_chkwd,
                vecs[i].e_wd, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_stall, vecs[i].e_ret);
      @(posedge clk); #1;
    end

    // Reset asserted while a load is outstanding, then a stale rvalid after release.
    drive(1, 1, 6, 0, 1, 2, 0, 0, 0, 6, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    #3;
    check_all("rst_pre", 0, 0, 6, 0, 0, 0, 0, 1, 0);
    reset_n = 1'b0;
    #1;
    check_all("rst_async", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    #3;
    check_all("rst_late_rvalid", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_all("rst_after", 1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    m_valid = 0; m_load = 0; m_wen = 0; m_wa = 0; m_wd = 0; m_mt = 0; m_lo = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      v = ($urandom_range(0, 1) == 1); w = ($urandom_range(0, 3) != 0);
      a = 5'($urandom_range(0, 7)); d = $urandom; ld = ($urandom_range(0, 1) == 1);
      mt = 3'($urandom_range(0, 7)); lo = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 9) < 4); rdata = $urandom;
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      drive(v, w, a, d, ld, mt, lo, rv, rdata, r1, r2);

      done  = m_valid && (!m_load || rv);
      rdy   = !(m_valid && m_load) || rv;
      ok    = !m_load || LBYP;
      ewen  = done && m_wen && (m_wa != 0);
      ewd   = m_load ? extract(m_mt, m_lo, rdata) : m_wd;
      stall = m_valid && m_load && m_wen && (m_wa != 0) && ((r1 == m_wa) || (r2 == m_wa)) && !(rv && ok);
      #3;
      check_all($sformatf("rand%0d", cyc), rdy, ewen, m_wa, done, ewd,
                ewen && ok && (r1 == m_wa), ewen && ok && (r2 == m_wa), stall, done);

      if (v && rdy) begin
        m_valid = 1; m_load = ld; m_wen = w; m_wa = a; m_wd = d; m_mt = mt; m_lo = lo;
      end else if (done) begin
        m_valid = 0;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscale_wb_stage.md
Name: vscale_wb_stage

Overview:
- Writeback stage directly upstream of the register file.
- Holds one retiring instruction from EX: either an ALU result or a pending load.
- Waits for the data-memory response and extracts/sign-extends load data.
- Drives the regfile write port (wen/wa/wd), the bypass_rs1/bypass_rs2/bypass_data inputs, and a load-use stall back to decode.

Parameters:
XPR_LEN, 32, datapath width
REG_ADDR_WIDTH, 5, register address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
ex_valid  in  1  EX presents an instruction to retire
ex_ready  out  1  WB accepts the EX instruction this cycle
ex_wen  in  1  instruction writes rd
ex_wa  in  REG_ADDR_WIDTH  destination register
ex_wd  in  XPR_LEN  ALU result (ignored for loads)
ex_is_load  in  1  instruction is a load
ex_mem_type  in  3  load funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5)
ex_addr_lo  in  2  load byte address [1:0]
dmem_rvalid  in  1  load data valid this cycle
dmem_rdata  in  XPR_LEN  load word, naturally aligned
de_ra1  in  REG_ADDR_WIDTH  decode rs1 address
de_ra2  in  REG_ADDR_WIDTH  decode rs2 address
wen  out  1  regfile write enable
wa  out  REG_ADDR_WIDTH  regfile write address
wd  out  XPR_LEN  regfile write data
bypass_rs1  out  1  decode rs1 takes bypass_data
bypass_rs2  out  1  decode rs2 takes bypass_data
bypass_data  out  XPR_LEN  forwarded value
load_use_stall  out  1  decode must hold
retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- Internal registers:
  - state in {EMPTY, ALU, LOAD_WAIT}
  - wb_wen, wb_wa, wb_data, wb_mem_type, wb_addr_lo
- Reset (reset_n low, asynchronous):
  - state=EMPTY; all wb_* registers cleared.
  - Consequently wen, bypass_rs1, bypass_rs2, load_use_stall and retire are 0, and wa/wd/bypass_data are 0.
  - ex_ready=1 immediately after reset.
  - A load in flight when reset asserts is discarded; a late dmem_rvalid arriving in EMPTY is ignored.
- ex_ready = (state != LOAD_WAIT) || dmem_rvalid.
- Accept when ex_valid && ex_ready:
  - Capture all ex_* fields.
  - Next state: LOAD_WAIT if ex_is_load, else ALU.
- No accept:
  - ALU goes to EMPTY.
  - LOAD_WAIT with dmem_rvalid goes to EMPTY.
  - LOAD_WAIT without dmem_rvalid stays in LOAD_WAIT indefinitely.
- Completion cycle = state==ALU, or state==LOAD_WAIT && dmem_rvalid.
  - retire=1.
  - wen = wb_wen && (wb_wa != 0).
  - wa = wb_wa.
  - wd = wb_data (ALU) or the extracted load value (LOAD_WAIT).
  - Outside completion cycles wen=0 and retire=0; wa/wd hold their last register values.
- Load extraction:
  - LB/LBU: byte at wb_addr_lo, sign-/zero-extended to XPR_LEN.
  - LH/LHU: halfword selected by wb_addr_lo[1]; wb_addr_lo[0] ignored; sign-/zero-extended.
  - LW and any undefined funct3: full word.
- Bypass:
  - bypass_rs1 = wen && byp_ok && de_ra1==wa; bypass_rs2 likewise with de_ra2.
  - bypass_data = wd.
  - byp_ok is 1 for ALU completions; for load completions it depends on the Optional Feature.
  - Register 0 is never bypassed, because wen is already 0 for wa=0.
- load_use_stall:
  - = (state==LOAD_WAIT) && wb_wen && wb_wa != 0 && (de_ra1==wb_wa || de_ra2==wb_wa) && !(dmem_rvalid && byp_ok).
  - Purely combinational; no extra latency.
- Simultaneous events:
  - A completion and a new accept in the same cycle are legal; back-to-back throughput is 1 per cycle for ALU ops and for loads answered in the next cycle.

Optional Feature:
- Macro: VSCALE_WB_LOAD_BYPASS_EN.
- Defined:
  - byp_ok=1 for load completions: extracted load data is forwarded in the dmem_rvalid cycle.
  - load_use_stall drops in that cycle.
- Undefined:
  - byp_ok=0 for load completions: loads are never bypassed.
  - load_use_stall remains high through the dmem_rvalid cycle; decode reads the register array from the following cycle.

Test Plan:
- Reset, then ALU op ex_wa=5, ex_wd=0x1234_5678 with de_ra1=5 -> next cycle: wen=1, wa=5, wd=0x12345678, bypass_rs1=1, retire=1; following cycle wen=0.
- ALU op to x0 (ex_wen=1, ex_wa=0, de_ra1=0) -> retire=1, wen=0, bypass_rs1=0.
- LB, addr_lo=3, dmem_rdata=0x80FF_0000, rvalid 3 cycles after accept, de_ra2=wb_wa:
  - ex_ready=0 and load_use_stall=1 for 2 cycles.
  - Then wd=0xFFFF_FF80, wen=1, retire=1.
  - Stall in the rvalid cycle is 0 if VSCALE_WB_LOAD_BYPASS_EN is defined, 1 if undefined.
- LHU addr_lo=2, rdata=0x9ABC_1234 -> wd=0x0000_9ABC; LH same data -> wd=0xFFFF_9ABC.
- Back-to-back ALU, ALU, load with rvalid the next cycle, ALU -> four retire pulses on consecutive cycles; ex_ready held at 1 throughout.
- reset_n low while in LOAD_WAIT, then rvalid=1 after release -> no wen, no retire; state EMPTY; ex_ready=1.
